// File: rtl/ex_div_seq.sv
// Radix-2 restoring divider for the EX stage: DIV/DIVU/REM/REMU and their W variants.
// Latency: 67 cycles (64-bit), 35 (W), 2 (divide-by-zero / signed overflow), start to done.
// Backpressure: holds EX through o_stall until the done cycle; i_flush abandons the op.
module ex_div_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam int HALF = XLEN / 2;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem, quo, dvsr;
  logic              neg_q, neg_r, op_rem, word_q;

  function automatic logic [XLEN-1:0] w_ext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation and special-case detection for the start cycle
  logic            is_signed, a_neg, b_neg, div_zero, ovf, special, start;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, most_neg, spec_sel;

  always_comb begin
    is_signed = ~i_op[0];
    a_ext = i_rs1;
    b_ext = i_rs2;
    if (i_word) begin
      a_ext = is_signed ? {{(XLEN-32){i_rs1[31]}}, i_rs1[31:0]} : {{(XLEN-32){1'b0}}, i_rs1[31:0]};
      b_ext = is_signed ? {{(XLEN-32){i_rs2[31]}}, i_rs2[31:0]} : {{(XLEN-32){1'b0}}, i_rs2[31:0]};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    most_neg = i_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = is_signed & (a_ext == most_neg) & (b_ext == '1);
    special  = div_zero | ovf;
    if (i_op[1]) spec_sel = div_zero ? a_ext : '0;
    else         spec_sel = div_zero ? '1 : a_ext;
    start    = (state == IDLE) & i_valid & ~i_flush;
  end

  // One restoring step: the shifted remainder needs XLEN+1 bits for the compare
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] quo_sh, q_fix, r_fix;
  logic            ge;

  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    quo_sh = {quo[XLEN-2:0], 1'b0};
    ge     = rem_sh >= {1'b0, dvsr};
    q_fix  = neg_q ? -quo : quo;
    r_fix  = neg_r ? -rem : rem;
  end

  always_comb begin
    state_n = state;
    o_stall = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        o_stall = 1'b1;
        state_n = special ? DONE : CALC;
      end
      CALC: begin
        o_stall = 1'b1;
        if (i_flush)                     state_n = IDLE;
        else if (cnt == CNT_W'(1))       state_n = FIX;
      end
      FIX: begin
        o_stall = 1'b1;
        state_n = i_flush ? IDLE : DONE;
      end
      DONE: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      op_rem   <= 1'b0;
      word_q   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      state  <= state_n;
      o_done <= (state_n == DONE);
      case (state)
        IDLE: if (start) begin
          op_rem <= i_op[1];
          word_q <= i_word;
          dvsr   <= b_abs;
          rem    <= '0;
          // W dividends sit in the upper half so 32 shifts consume exactly their bits
          quo    <= i_word ? (a_abs << HALF) : a_abs;
          cnt    <= i_word ? CNT_W'(HALF) : CNT_W'(XLEN);
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          if (special) o_result <= w_ext(i_word, spec_sel);
        end
        CALC: begin
          rem <= ge ? (rem_sh[XLEN-1:0] - dvsr) : rem_sh[XLEN-1:0];
          quo <= {quo_sh[XLEN-1:1], ge};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: if (!i_flush) o_result <= w_ext(word_q, op_rem ? r_fix : q_fix);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: results, latency, stall profile, flush and reset behaviour.
module tb_ex_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [1:0]  i_op;
  logic        i_word;
  logic [63:0] i_rs1, i_rs2;
  logic        i_flush;
  logic        o_stall, o_done;
  logic [63:0] o_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_div_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_op(i_op), .i_word(i_word),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
    .o_stall(o_stall), .o_done(o_done), .o_result(o_result)
  );

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  // Presents one op from the current cycle (cycle 1) and keeps i_valid high until done
  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int   cyc = 1;
    int   stalls = 0;
    int   lat = 0;
    logic done_stall = 1'b1;
    i_valid = 1'b1; i_op = op; i_word = w; i_rs1 = a; i_rs2 = b; i_flush = 1'b0;
    while (cyc <= 200) begin
      #1;
      if (o_done) begin
        lat = cyc;
        done_stall = o_stall;
        break;
      end
      if (o_stall) stalls++;
      next_cyc();
      cyc++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, o_result, exp);
    chk({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat - 1));
    chk({tag, " stall in done"}, 64'(done_stall), 64'd0);
    i_valid = 1'b0;
    next_cyc();
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_word = 1'b0;
    i_rs1 = '0; i_rs2 = '0; i_flush = 1'b0;
    next_cyc();
    next_cyc();
    chk("reset done", 64'(o_done), 64'd0);
    chk("reset result", o_result, 64'd0);
    chk("reset stall", 64'(o_stall), 64'd0);
    rst_n = 1'b1;
    next_cyc();

    run_op("div 100/-7",    OP_DIV,  1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 67);
    run_op("rem -100%7",    OP_REM,  1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 67);
    run_op("remu max%16",   OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'hF, 67);
    run_op("divu max/16",   OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 67);
    run_op("div -100/-7",   OP_DIV,  1'b0, -64'sd100, -64'sd7, 64'd14, 67);
    run_op("divu 5/0",      OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_op("rem 5/0",       OP_REM,  1'b0, 64'd5, 64'd0, 64'd5, 2);
    run_op("div ovf",       OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
    run_op("rem ovf",       OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
    run_op("divw ovf",      OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2);
    run_op("divuw max/1",   OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35);
    run_op("divw -16/3",    OP_DIV,  1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 35);
    run_op("remw -100%7",   OP_REM,  1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 35);
    run_op("remuw 100%7",   OP_REMU, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd2, 35);
    run_op("remuw 0/0",     OP_REMU, 1'b1, 64'hABCD_0000_8000_0001, 64'h5555_5555_0000_0000, 64'hFFFF_FFFF_8000_0001, 2);

    // Flush during CALC cycle 10
    i_valid = 1'b1; i_op = OP_DIV; i_word = 1'b0; i_rs1 = 64'd100; i_rs2 = 64'd7;
    for (int k = 0; k < 10; k++) next_cyc();
    i_flush = 1'b1;
    next_cyc();
    i_valid = 1'b0; i_flush = 1'b0;
    #1;
    chk("flush idle stall", 64'(o_stall), 64'd0);
    chk("flush no done", 64'(o_done), 64'd0);
    next_cyc();
    run_op("divu 9/3 after flush", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 67);

    // Flush together with a request in IDLE must not start anything
    i_valid = 1'b1; i_flush = 1'b1; i_op = OP_DIV; i_rs1 = 64'd50; i_rs2 = 64'd5;
    #1;
    chk("idle flush stall", 64'(o_stall), 64'd0);
    next_cyc();
    i_valid = 1'b0; i_flush = 1'b0;
    #1;
    chk("idle flush no start", 64'(o_stall), 64'd0);
    next_cyc();

    // Reset during CALC cycle 20, with i_valid held throughout
    i_valid = 1'b1; i_op = OP_DIV; i_word = 1'b0; i_rs1 = 64'd100; i_rs2 = -64'sd7;
    for (int k = 0; k < 20; k++) next_cyc();
    rst_n = 1'b0;
    next_cyc();
    chk("mid reset done", 64'(o_done), 64'd0);
    chk("mid reset result", o_result, 64'd0);
    next_cyc();
    chk("held reset done", 64'(o_done), 64'd0);
    rst_n = 1'b1;
    run_op("div after reset", OP_DIV, 1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 67);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Iterative radix-2 divider sequencer for the EX stage of the RV64 pipeline.
- Executes DIV, DIVU, REM, REMU and their W variants (DIVW, DIVUW, REMW, REMUW).
- Drives the EX-stage staller so the instruction is held in EX while the divide runs.
- Delivers a final 64-bit result that the EX stage writes into rf_wr_data. For W ops the result is already sign-extended, so the downstream sign-extend step is a no-op for them.

Parameters:
- XLEN, 64, operand and result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  a valid divide instruction is present in EX.
- i_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_word  input  1  1 = W variant (32-bit operation).
- i_rs1  input  XLEN  dividend.
- i_rs2  input  XLEN  divisor.
- i_flush  input  1  kill the in-flight operation (branch mispredict or trap).
- o_stall  output  1  EX staller request; combinational.
- o_done  output  1  result valid this cycle; registered.
- o_result  output  XLEN  quotient or remainder; registered.

Behaviour:
- States: IDLE, CALC, FIX, DONE. Two-bit state register.
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; counter, working registers, o_done and o_result all go to 0.
  - Reset takes priority over every other input. If reset hits mid-operation, the operation is abandoned with no o_done.
- Stall: o_stall = (IDLE & i_valid & !i_flush) | CALC | FIX. o_stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- IDLE with i_valid=1 (start). Latch op, word flag and operands.
- Operand preparation:
  - W ops take the low 32 bits of each operand.
  - Signed ops (DIV, REM) sign-extend those bits; unsigned ops zero-extend them.
  - Signed ops then take the absolute value of each operand and record neg_q = sign(a) XOR sign(b), and neg_r = sign(a).
- Iteration count N: 64 for 64-bit ops, 32 for W ops. The counter is loaded with N.
- Special cases, detected in IDLE; these go IDLE -> DONE directly with no CALC:
  - Divisor = 0 (after W truncation): quotient = all ones, remainder = dividend (after W extension).
  - Signed overflow (dividend = most negative value for the width, divisor = -1): quotient = dividend, remainder = 0.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem >= divisor: subtract divisor from rem and set quo[0] = 1.
  - Decrement the counter; when it reaches 1, go to FIX on the next edge.
- FIX:
  - Apply sign correction: negate quo if neg_q, negate rem if neg_r. Signed ops only.
  - Select quo for DIV/DIVU and rem for REM/REMU.
  - W ops: o_result = sign-extension of the selected value's bit 31, including DIVUW and REMUW.
  - Register o_result and o_done=1, then go to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE. A request is never accepted in DONE; new requests are accepted only in IDLE.
- o_done is 0 in every state except DONE. o_result holds its last value until the next FIX or special completion.
- Latency, counted from the start cycle to the DONE cycle inclusive:
  - 64-bit normal op: N+3 = 67 cycles, o_stall high for 66 of them.
  - W normal op: 35 cycles.
  - Special case: 2 cycles.
- i_flush:
  - In any state other than reset, the next state is IDLE with o_done=0.
  - i_flush in IDLE together with i_valid does not start an operation.
  - i_flush asserted in DONE still suppresses nothing already visible: o_done stays 1 in that cycle, and the EX stage discards it via is_valid.
- All arithmetic is unsigned on XLEN+1-bit remainder arithmetic to hold the compare carry. Negation is two's complement within XLEN.

Test Plan:
- DIV rs1=100, rs2=-7 -> o_result=0xFFFFFFFFFFFFFFF2 (-14); o_done in cycle 67 after start; o_stall high cycles 1-66, low in cycle 67.
- REM rs1=-100, rs2=7 -> o_result=0xFFFFFFFFFFFFFFFE (-2); REMU rs1=0xFFFFFFFFFFFFFFFF, rs2=16 -> 0xF.
- DIVU rs1=5, rs2=0 -> all ones, o_done at cycle 2; REM rs1=5, rs2=0 -> 5; DIV 0x8000000000000000 / -1 -> 0x8000000000000000; REM of the same operands -> 0.
- DIVW rs1=0x0000000080000000, rs2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000 (overflow path); DIVUW rs1=0x12345678FFFFFFFF, rs2=1 -> 0xFFFFFFFFFFFFFFFF after 35 cycles.
- Start DIV, assert i_flush in CALC cycle 10 -> IDLE next cycle, no o_done, o_stall=0. A new DIVU 9/3 presented the following cycle -> 3 after 67 cycles.
- Drop rst_n low in CALC cycle 20 -> next edge: IDLE, o_done=0, o_result=0. i_valid held during reset does not start an operation until rst_n=1.
